// File: rtl/motor_drive_sequencer.sv
// rtl/motor_drive_sequencer.sv - soft start / run / soft stop / hold-off motor sequencer
// Optional RUN timeout enabled by defining SEQ_RUN_TIMEOUT_EN.

module motor_drive_sequencer #(
    parameter int PWM_RESOLUTION    = 17,
    parameter int BASE_DUTY         = 32768,
    parameter int RAMP_STEP         = 1024,
    parameter int HOLDOFF_TICKS     = 32,
    parameter int RUN_TIMEOUT_TICKS = 1920
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clk_en,
    input  logic                      start_pulse,
    input  logic                      kill_sw,
    output logic                      motor_en,
    output logic                      pid_en,
    output logic [PWM_RESOLUTION-1:0] base_duty,
    output logic                      busy,
    output logic [2:0]                state
);

    localparam int DW = PWM_RESOLUTION;
    localparam int HW = $clog2(HOLDOFF_TICKS + 1);
    localparam logic [DW:0] BASE_W = (DW+1)'(BASE_DUTY);
    // A step at or above the target is clamped so one tick lands exactly on BASE_DUTY or 0.
    localparam logic [DW:0] STEP_W = (RAMP_STEP >= BASE_DUTY) ? BASE_W : (DW+1)'(RAMP_STEP);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_RUN       = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   duty_q, duty_d;
    logic            motor_q, motor_d;
    logic            pid_q, pid_d;
    logic            busy_q, busy_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [DW:0]     sum_up;
    logic [DW-1:0]   diff_down;

`ifdef SEQ_RUN_TIMEOUT_EN
    localparam int RW = $clog2(RUN_TIMEOUT_TICKS + 1);
    logic [RW-1:0]   run_q, run_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            motor_q <= 1'b0;
            pid_q   <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
`ifdef SEQ_RUN_TIMEOUT_EN
            run_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            motor_q <= motor_d;
            pid_q   <= pid_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
`ifdef SEQ_RUN_TIMEOUT_EN
            run_q   <= run_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        motor_d   = motor_q;
        pid_d     = pid_q;
        hold_d    = hold_q;
`ifdef SEQ_RUN_TIMEOUT_EN
        run_d     = run_q;
`endif
        sum_up    = {1'b0, duty_q} + STEP_W;
        diff_down = duty_q - STEP_W[DW-1:0];

        if (kill_sw) begin
            state_d = S_IDLE;
            duty_d  = '0;
            motor_d = 1'b0;
            pid_d   = 1'b0;
            hold_d  = '0;
`ifdef SEQ_RUN_TIMEOUT_EN
            run_d   = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    duty_d  = '0;
                    motor_d = 1'b0;
                    pid_d   = 1'b0;
                    hold_d  = '0;
                    if (start_pulse) begin
                        state_d = S_RAMP_UP;
                        motor_d = 1'b1;
                    end
                end
                S_RAMP_UP: begin
                    motor_d = 1'b1;
                    pid_d   = 1'b0;
                    // A reversal on a tick cycle freezes the duty where it is.
                    if (start_pulse) begin
                        state_d = S_RAMP_DOWN;
                    end else if (clk_en) begin
                        if (sum_up >= BASE_W) begin
                            duty_d  = BASE_W[DW-1:0];
                            state_d = S_RUN;
                            pid_d   = 1'b1;
`ifdef SEQ_RUN_TIMEOUT_EN
                            run_d   = '0;
`endif
                        end else begin
                            duty_d = sum_up[DW-1:0];
                        end
                    end
                end
                S_RUN: begin
                    duty_d  = BASE_W[DW-1:0];
                    motor_d = 1'b1;
                    pid_d   = 1'b1;
                    if (start_pulse) begin
                        state_d = S_RAMP_DOWN;
                        pid_d   = 1'b0;
                    end
`ifdef SEQ_RUN_TIMEOUT_EN
                    else if (clk_en) begin
                        if (run_q == RW'(RUN_TIMEOUT_TICKS - 1)) begin
                            state_d = S_RAMP_DOWN;
                            pid_d   = 1'b0;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end
`endif
                end
                S_RAMP_DOWN: begin
                    motor_d = 1'b1;
                    pid_d   = 1'b0;
                    if (clk_en) begin
                        if ({1'b0, duty_q} <= STEP_W) begin
                            duty_d  = '0;
                            state_d = S_HOLDOFF;
                            motor_d = 1'b0;
                            hold_d  = '0;
                        end else begin
                            duty_d = diff_down;
                        end
                    end
                end
                S_HOLDOFF: begin
                    duty_d  = '0;
                    motor_d = 1'b0;
                    pid_d   = 1'b0;
                    if (clk_en) begin
                        if (hold_q == HW'(HOLDOFF_TICKS - 1)) begin
                            state_d = S_IDLE;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    duty_d  = '0;
                    motor_d = 1'b0;
                    pid_d   = 1'b0;
                    hold_d  = '0;
                end
            endcase
        end

        busy_d = (state_d == S_RAMP_UP) || (state_d == S_RAMP_DOWN) || (state_d == S_HOLDOFF);
    end

    assign state     = state_q;
    assign base_duty = duty_q;
    assign motor_en  = motor_q;
    assign pid_en    = pid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb/tb_motor_drive_sequencer.sv - table-driven bench for motor_drive_sequencer

module tb_motor_drive_sequencer;

    localparam int PW = 17;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clk_en = 1'b0;
    logic          start_pulse = 1'b0;
    logic          kill_sw = 1'b0;
    logic          motor_en, pid_en, busy;
    logic [PW-1:0] base_duty;
    logic [2:0]    state;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          ce, sp, ks;
        logic [2:0]    st;
        logic [PW-1:0] duty;
        logic          men, pen, bsy;
    } vec_t;

    vec_t vecs[$];

    motor_drive_sequencer #(
        .PWM_RESOLUTION(PW), .BASE_DUTY(32768), .RAMP_STEP(4096),
        .HOLDOFF_TICKS(4), .RUN_TIMEOUT_TICKS(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start_pulse(start_pulse),
        .kill_sw(kill_sw), .motor_en(motor_en), .pid_en(pid_en),
        .base_duty(base_duty), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic add(input logic ce, sp, ks, input logic [2:0] st, input int duty,
                       input logic men, pen, bsy);
        vec_t v;
        v.ce = ce; v.sp = sp; v.ks = ks; v.st = st; v.duty = PW'(duty);
        v.men = men; v.pen = pen; v.bsy = bsy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [2:0] st, input logic [PW-1:0] duty,
                       input logic men, pen, bsy);
        checks++;
        if (state !== st || base_duty !== duty || motor_en !== men || pid_en !== pen || busy !== bsy) begin
            failures++;
            $display("FAIL %s: got state=%0d duty=%0d motor_en=%0b pid_en=%0b busy=%0b, expected state=%0d duty=%0d motor_en=%0b pid_en=%0b busy=%0b",
                     name, state, base_duty, motor_en, pid_en, busy, st, duty, men, pen, bsy);
        end
    endtask

    task automatic step(input logic ce, sp, ks);
        @(negedge clk);
        clk_en = ce; start_pulse = sp; kill_sw = ks;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Soft start: 8 ticks of 4096 reach 32768 and enter RUN.
        add(0,0,0, 0, 0,     0,0,0);
        add(0,1,0, 1, 0,     1,0,1);
        for (int k = 1; k < 8; k++) add(1,0,0, 1, 4096*k, 1,0,1);
        add(1,0,0, 2, 32768, 1,1,0);
        add(0,0,0, 2, 32768, 1,1,0);
        // Soft stop, then hold-off with ignored start pulses.
        add(0,1,0, 3, 32768, 1,0,1);
        for (int k = 1; k < 8; k++) add(1,0,0, 3, 32768-4096*k, 1,0,1);
        add(1,0,0, 4, 0,     0,0,1);
        add(0,1,0, 4, 0,     0,0,1);
        add(1,0,0, 4, 0,     0,0,1);
        add(1,1,0, 4, 0,     0,0,1);
        add(1,0,0, 4, 0,     0,0,1);
        add(1,0,0, 0, 0,     0,0,0);
        // Mid-ramp reversal coincident with a tick.
        add(0,1,0, 1, 0,     1,0,1);
        for (int k = 1; k <= 3; k++) add(1,0,0, 1, 4096*k, 1,0,1);
        add(1,1,0, 3, 12288, 1,0,1);
        add(0,1,0, 3, 12288, 1,0,1);
        add(1,0,0, 3, 8192,  1,0,1);
        add(1,0,0, 3, 4096,  1,0,1);
        add(1,0,0, 4, 0,     0,0,1);
        for (int k = 1; k < 4; k++) add(1,0,0, 4, 0, 0,0,1);
        add(1,0,0, 0, 0,     0,0,0);
        // Kill override from RUN and from RAMP_UP.
        add(0,1,0, 1, 0,     1,0,1);
        for (int k = 1; k < 8; k++) add(1,0,0, 1, 4096*k, 1,0,1);
        add(1,0,0, 2, 32768, 1,1,0);
        add(0,1,1, 0, 0,     0,0,0);
        add(1,1,1, 0, 0,     0,0,0);
        add(0,1,1, 0, 0,     0,0,0);
        add(0,1,0, 1, 0,     1,0,1);
        add(1,0,0, 1, 4096,  1,0,1);
        add(1,0,1, 0, 0,     0,0,0);

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ce, vecs[i].sp, vecs[i].ks);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].duty, vecs[i].men, vecs[i].pen, vecs[i].bsy);
        end

        // Asynchronous reset between edges in RAMP_DOWN.
        step(0,1,0);
        step(1,0,0);
        step(1,0,0);
        step(0,1,0);
        step(1,0,0);
        chk("pre_async", 3, 4096, 1, 0, 1);
        @(negedge clk);
        clk_en = 1'b0; start_pulse = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // RUN persistence versus timeout.
        step(0,1,0);
        for (int k = 0; k < 8; k++) step(1,0,0);
        chk("run_entry", 2, 32768, 1, 1, 0);
`ifdef SEQ_RUN_TIMEOUT_EN
        for (int k = 0; k < 4; k++) step(1,0,0);
        chk("run_before_timeout", 2, 32768, 1, 1, 0);
        step(1,0,0);
        chk("run_timeout", 3, 32768, 1, 0, 1);
`else
        for (int k = 0; k < 100; k++) step(1,0,0);
        chk("run_no_timeout", 2, 32768, 1, 1, 0);
`endif
        step(0,0,1);
        chk("final_kill", 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
